// File: rtl/gpio_hm2_adapter_pkg.sv
// Shared definitions for the HostMot2 <-> DE0-Nano GPIO pad adapter.
// Holds the board geometry, the timing defaults and the adapter state encoding.
package gpio_hm2_adapter_pkg;

   localparam int unsigned IOWidth        = 72;
   localparam int unsigned NumGPIO        = 2;
   localparam int unsigned MuxGPIOIOWidth = 36;
   localparam int unsigned LEDCount       = 2;
   localparam int unsigned HoldoffCycles  = 1024;
   localparam int unsigned StretchCycles  = 5000000;

   // Visible on adapter_state; 2'd3 is unused and recovers to SAFE.
   typedef enum logic [1:0] {
      HOLDOFF = 2'd0,
      RUN     = 2'd1,
      SAFE    = 2'd2
   } adapter_state_t;

endpackage

// File: rtl/gpio_hm2_adapter_led_stretch.sv
// LED pulse stretcher: keeps a board LED lit for at least StretchCycles after
// each rising edge of the core's LED request. A new edge while counting retriggers.
// Ports:
//   clklow_i   system clock
//   reset_i    synchronous active-high reset
//   led_req_i  LED request from the core
//   led_o      registered, stretched LED drive (1 = lit)
module gpio_hm2_adapter_led_stretch #(
   parameter int unsigned StretchCycles = 5000000
) (
   input  logic clklow_i,
   input  logic reset_i,
   input  logic led_req_i,
   output logic led_o
);

   localparam int unsigned CntW = $clog2(StretchCycles) + 1;

   logic            req_q;
   logic            led_q, led_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (led_req_i && !req_q) begin
         cnt_d = CntW'(StretchCycles - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CntW'(1);
      end
      led_d = led_req_i | (cnt_q != '0);
   end

   always_ff @(posedge clklow_i) begin
      if (reset_i) begin
         req_q <= 1'b0;
         cnt_q <= '0;
         led_q <= 1'b0;
      end else begin
         req_q <= led_req_i;
         cnt_q <= cnt_d;
         led_q <= led_d;
      end
   end

   assign led_o = led_q;

endmodule

// File: rtl/gpio_hm2_adapter.sv
// Pad-side stage between HostMot2 IOBits and the two DE0-Nano GPIO headers.
// Identity pin mapping, 2-FF input synchronizers, registered outputs/enables,
// tri-state holdoff after reset or a watchdog bite, and LED stretching.
// Ports:
//   clklow, reset          clock and synchronous active-high reset
//   hm2_out/hm2_oe/hm2_in  core side data, enable (1=drive), synchronized inputs
//   hm2_leds               core LED requests
//   hm2_wd_bite            core watchdog bite (level)
//   safe_clear             pulse that leaves SAFE
//   gpio_in/out/oe         header pad side
//   led_out                board LEDs
//   adapter_state          HOLDOFF=0, RUN=1, SAFE=2
module gpio_hm2_adapter #(
   parameter int unsigned IOWidth        = gpio_hm2_adapter_pkg::IOWidth,
   parameter int unsigned NumGPIO        = gpio_hm2_adapter_pkg::NumGPIO,
   parameter int unsigned MuxGPIOIOWidth = gpio_hm2_adapter_pkg::MuxGPIOIOWidth,
   parameter int unsigned LEDCount       = gpio_hm2_adapter_pkg::LEDCount,
   parameter int unsigned HoldoffCycles  = gpio_hm2_adapter_pkg::HoldoffCycles,
   parameter int unsigned StretchCycles  = gpio_hm2_adapter_pkg::StretchCycles,
   parameter int unsigned BoardAdaptor   = 0
) (
   input  logic                clklow,
   input  logic                reset,
   input  logic [IOWidth-1:0]  hm2_out,
   input  logic [IOWidth-1:0]  hm2_oe,
   output logic [IOWidth-1:0]  hm2_in,
   input  logic [LEDCount-1:0] hm2_leds,
   input  logic                hm2_wd_bite,
   input  logic                safe_clear,
   input  logic [IOWidth-1:0]  gpio_in,
   output logic [IOWidth-1:0]  gpio_out,
   output logic [IOWidth-1:0]  gpio_oe,
   output logic [LEDCount-1:0] led_out,
   output logic [1:0]          adapter_state
);

   import gpio_hm2_adapter_pkg::*;

   localparam int unsigned HoldW = (HoldoffCycles > 1) ? $clog2(HoldoffCycles) : 1;

   if (BoardAdaptor != 0) begin : g_bad_adaptor
      $error("gpio_hm2_adapter: only BoardAdaptor=0 (STRAIGHT) is supported");
   end
   if (IOWidth != NumGPIO * MuxGPIOIOWidth) begin : g_bad_width
      $error("gpio_hm2_adapter: IOWidth must equal NumGPIO*MuxGPIOIOWidth");
   end
   if (HoldoffCycles < 1 || StretchCycles < 1) begin : g_bad_timing
      $error("gpio_hm2_adapter: HoldoffCycles and StretchCycles must be >= 1");
   end

   logic [IOWidth-1:0] sync1_q, sync2_q;
   logic [IOWidth-1:0] gpio_out_q;
   logic [IOWidth-1:0] gpio_oe_q, gpio_oe_d;
   adapter_state_t     state_q, state_d;
   logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = HoldW'(HoldoffCycles - 1);
      case (state_q)
         HOLDOFF: begin
            if (hm2_wd_bite) begin
               state_d = SAFE;
            end else if (hold_cnt_q == '0) begin
               state_d = RUN;
            end else begin
               hold_cnt_d = hold_cnt_q - HoldW'(1);
            end
         end
         RUN: begin
            if (hm2_wd_bite) state_d = SAFE;
         end
         SAFE: begin
            if (safe_clear && !hm2_wd_bite) state_d = HOLDOFF;
         end
         default: state_d = SAFE;
      endcase
      // Enables drive only once RUN is established, and drop on the bite edge itself.
      gpio_oe_d = (state_q == RUN && state_d == RUN) ? hm2_oe : '0;
   end

   always_ff @(posedge clklow) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         gpio_out_q <= '0;
         gpio_oe_q  <= '0;
         state_q    <= HOLDOFF;
         // Preloaded so the holdoff length counts from reset release.
         hold_cnt_q <= HoldW'(HoldoffCycles - 1);
      end else begin
         sync1_q    <= gpio_in;
         sync2_q    <= sync1_q;
         gpio_out_q <= hm2_out;
         gpio_oe_q  <= gpio_oe_d;
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   for (genvar i = 0; i < int'(LEDCount); i++) begin : g_led
      gpio_hm2_adapter_led_stretch #(
         .StretchCycles(StretchCycles)
      ) u_led_stretch (
         .clklow_i (clklow),
         .reset_i  (reset),
         .led_req_i(hm2_leds[i]),
         .led_o    (led_out[i])
      );
   end

   assign hm2_in        = sync2_q;
   assign gpio_out      = gpio_out_q;
   assign gpio_oe       = gpio_oe_q;
   assign adapter_state = state_q;

endmodule

// File: tb/tb_gpio_hm2_adapter.sv
module tb_gpio_hm2_adapter;

   localparam int W = 72;
   localparam int H = 16;
   localparam int S = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  hm2_out, hm2_oe, gpio_in;
   logic [1:0]    hm2_leds;
   logic          hm2_wd_bite, safe_clear;
   logic [W-1:0]  hm2_in, gpio_out, gpio_oe;
   logic [1:0]    led_out;
   logic [1:0]    adapter_state;

   always #5 clk = ~clk;

   gpio_hm2_adapter #(
      .HoldoffCycles(H),
      .StretchCycles(S)
   ) dut (
      .clklow       (clk),
      .reset        (reset),
      .hm2_out      (hm2_out),
      .hm2_oe       (hm2_oe),
      .hm2_in       (hm2_in),
      .hm2_leds     (hm2_leds),
      .hm2_wd_bite  (hm2_wd_bite),
      .safe_clear   (safe_clear),
      .gpio_in      (gpio_in),
      .gpio_out     (gpio_out),
      .gpio_oe      (gpio_oe),
      .led_out      (led_out),
      .adapter_state(adapter_state)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model state (edge-indexed, derived from the behavioural rules).
   int           edge_n = 0;
   int           since_rst = 0;
   int           mode = 0;        // 0 holdoff, 1 run, 2 safe
   int           age = 0;         // edges spent in holdoff
   logic [W-1:0] last_in = '0;
   logic [W-1:0] e_hm2_in = '0, e_gpio_out = '0, e_gpio_oe = '0;
   logic [1:0]   e_led = '0, prev_led = '0;
   int           last_rise [2];
   bit           rise_valid [2];

   function automatic logic [W-1:0] rand72();
      logic [W-1:0] r;
      r[31:0]  = $urandom();
      r[63:32] = $urandom();
      r[71:64] = 8'($urandom());
      return r;
   endfunction

   // Advance one clock edge, update the model with the inputs seen at that edge.
   task automatic step();
      int old_mode;
      @(posedge clk);
      edge_n++;
      if (reset) begin
         mode = 0; age = 0; since_rst = 0;
         e_hm2_in = '0; e_gpio_out = '0; e_gpio_oe = '0; e_led = '0; prev_led = '0;
         rise_valid[0] = 0; rise_valid[1] = 0;
      end else begin
         if (since_rst < 1000) since_rst++;
         e_hm2_in   = (since_rst >= 2) ? last_in : '0;
         e_gpio_out = hm2_out;
         old_mode = mode;
         if (mode == 0) begin
            if (hm2_wd_bite) mode = 2;
            else begin
               age++;
               if (age >= H) mode = 1;
            end
         end else if (mode == 1) begin
            if (hm2_wd_bite) mode = 2;
         end else if (safe_clear && !hm2_wd_bite) begin
            mode = 0; age = 0;
         end
         e_gpio_oe = (old_mode == 1 && mode == 1) ? hm2_oe : '0;
         for (int i = 0; i < 2; i++) begin
            if (hm2_leds[i] && !prev_led[i]) begin
               last_rise[i] = edge_n; rise_valid[i] = 1;
            end
            e_led[i] = hm2_leds[i] || (rise_valid[i] && (edge_n - last_rise[i] <= S - 1));
            prev_led[i] = hm2_leds[i];
         end
      end
      last_in = gpio_in;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; hm2_oe = '1; hm2_out = rand72(); gpio_in = rand72();
      hm2_leds = 2'b00; hm2_wd_bite = 1'b0; safe_clear = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         vectors++;
         if (gpio_oe !== '0 || gpio_out !== '0 || led_out !== 2'b00 ||
             adapter_state !== 2'd0 || hm2_in !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs cyc=%0d oe=%h out=%h led=%b st=%0d in=%h required all 0",
                     c, gpio_oe, gpio_out, led_out, adapter_state, hm2_in);
         end
      end
      reset = 1'b0;
      for (int k = 1; k <= H + 1; k++) begin
         step();
         vectors++;
         if (gpio_oe !== ((k <= H) ? '0 : {W{1'b1}})) begin
            miscompares++;
            $display("FAIL holdoff_oe edge=%0d got %h", k, gpio_oe);
         end
         vectors++;
         if (adapter_state !== ((k < H) ? 2'd0 : 2'd1)) begin
            miscompares++;
            $display("FAIL holdoff_state edge=%0d got %0d exp %0d", k, adapter_state,
                     (k < H) ? 0 : 1);
         end
      end
   endtask

   task automatic test_sync_path();
      logic [W-1:0] pat;
      logic [W-1:0] a5;
      gpio_in = '0;
      repeat (3) step();
      pat = '0; pat[0] = 1'b1; pat[W-1] = 1'b1;
      a5 = {9{8'hA5}};
      gpio_in = pat; hm2_out = a5;
      step();
      vectors++;
      if (hm2_in !== '0) begin
         miscompares++; $display("FAIL sync_early got %h exp 0", hm2_in);
      end
      vectors++;
      if (gpio_out !== a5) begin
         miscompares++; $display("FAIL out_reg got %h exp %h", gpio_out, a5);
      end
      step();
      vectors++;
      if (hm2_in !== pat) begin
         miscompares++; $display("FAIL sync_two_edges got %h exp %h", hm2_in, pat);
      end
   endtask

   task automatic test_watchdog();
      hm2_oe = rand72() | 72'h1;
      step();
      hm2_wd_bite = 1'b1;
      step();
      hm2_wd_bite = 1'b0;
      vectors++;
      if (gpio_oe !== '0 || adapter_state !== 2'd2) begin
         miscompares++;
         $display("FAIL bite_edge oe=%h st=%0d exp oe=0 st=2", gpio_oe, adapter_state);
      end
      repeat (3) step();
      vectors++;
      if (adapter_state !== 2'd2 || gpio_oe !== '0) begin
         miscompares++; $display("FAIL safe_hold st=%0d exp 2", adapter_state);
      end
      safe_clear = 1'b1; hm2_wd_bite = 1'b1;
      step();
      safe_clear = 1'b0; hm2_wd_bite = 1'b0;
      vectors++;
      if (adapter_state !== 2'd2) begin
         miscompares++; $display("FAIL clear_with_bite st=%0d exp 2", adapter_state);
      end
      step();
      safe_clear = 1'b1;
      step();
      safe_clear = 1'b0;
      vectors++;
      if (adapter_state !== 2'd0) begin
         miscompares++; $display("FAIL clear_to_holdoff st=%0d exp 0", adapter_state);
      end
      for (int k = 1; k <= H + 1; k++) begin
         step();
         vectors++;
         if (adapter_state !== ((k < H) ? 2'd0 : 2'd1) ||
             gpio_oe !== ((k <= H) ? '0 : hm2_oe)) begin
            miscompares++;
            $display("FAIL reholdoff edge=%0d st=%0d oe=%h", k, adapter_state, gpio_oe);
         end
      end
   endtask

   task automatic test_led_stretch();
      int high_cnt;
      int last_high;
      hm2_leds = 2'b00;
      repeat (2) step();
      hm2_leds = 2'b01;
      high_cnt = 0;
      for (int e = 0; e < 12; e++) begin
         step();
         hm2_leds = 2'b00;
         if (led_out[0]) high_cnt++;
         vectors++;
         if (led_out[1] !== 1'b0 || led_out !== e_led) begin
            miscompares++; $display("FAIL led_single e=%0d got %b exp %b", e, led_out, e_led);
         end
      end
      vectors++;
      if (high_cnt != S) begin
         miscompares++; $display("FAIL led_width got %0d exp %0d", high_cnt, S);
      end
      hm2_leds = 2'b01;
      high_cnt = 0; last_high = -1;
      for (int e = 0; e < 18; e++) begin
         step();
         hm2_leds = (e == 4) ? 2'b01 : 2'b00;
         if (led_out[0]) begin high_cnt++; last_high = e; end
         vectors++;
         if (led_out !== e_led) begin
            miscompares++; $display("FAIL led_retrig e=%0d got %b exp %b", e, led_out, e_led);
         end
      end
      vectors++;
      if (last_high != 5 + S - 1 || high_cnt != 5 + S) begin
         miscompares++;
         $display("FAIL led_extend last=%0d cnt=%0d exp last=%0d cnt=%0d", last_high, high_cnt,
                  5 + S - 1, 5 + S);
      end
   endtask

   task automatic test_reset_mid();
      hm2_wd_bite = 1'b1;
      step();
      hm2_wd_bite = 1'b0; hm2_leds = 2'b11;
      step();
      hm2_leds = 2'b00;
      repeat (2) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      vectors++;
      if (gpio_oe !== '0 || gpio_out !== '0 || led_out !== 2'b00 ||
          adapter_state !== 2'd0 || hm2_in !== '0) begin
         miscompares++;
         $display("FAIL mid_reset oe=%h out=%h led=%b st=%0d in=%h required all 0",
                  gpio_oe, gpio_out, led_out, adapter_state, hm2_in);
      end
      for (int k = 1; k <= H; k++) begin
         step();
         vectors++;
         if (adapter_state !== ((k < H) ? 2'd0 : 2'd1) || led_out !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_reset_holdoff edge=%0d st=%0d led=%b", k, adapter_state, led_out);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         hm2_out = rand72(); hm2_oe = rand72(); gpio_in = rand72();
         reset = ($urandom_range(0, 199) == 0);
         hm2_wd_bite = ($urandom_range(0, 39) == 0);
         safe_clear = ($urandom_range(0, 5) == 0);
         for (int i = 0; i < 2; i++)
            if ($urandom_range(0, 9) == 0) hm2_leds[i] = ~hm2_leds[i];
         step();
         vectors++;
         if (hm2_in !== e_hm2_in || gpio_out !== e_gpio_out || gpio_oe !== e_gpio_oe ||
             led_out !== e_led || adapter_state !== 2'(mode)) begin
            miscompares++;
            $display("FAIL rand c=%0d in=%h/%h out=%h/%h oe=%h/%h led=%b/%b st=%0d/%0d", c,
                     hm2_in, e_hm2_in, gpio_out, e_gpio_out, gpio_oe, e_gpio_oe,
                     led_out, e_led, adapter_state, mode);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sync_path();
      test_watchdog();
      test_led_stretch();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
